// File: rtl/seq_disp_pkg.sv
// Shared types and active-low glyph constants for the detection counter display.
package seq_disp_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg7_t;

    // Segment order {g,f,e,d,c,b,a}, 0 = segment lit
    localparam seg7_t SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };
    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_ERR   = 7'b0000111;

    typedef enum logic {
        PH_SHOW  = 1'b0,
        PH_BLANK = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/detect_count_display_if.sv
// Control inputs and count/display outputs of detect_count_display.
interface detect_count_display_if;
    import seq_disp_pkg::*;

    logic       ena;
    logic       clr;
    logic       det;
    logic [7:0] count_bcd;
    logic       ovf;
    seg7_t      disp0;
    seg7_t      disp1;

    modport master (output ena, clr, det, input count_bcd, ovf, disp0, disp1);
    modport slave  (input ena, clr, det, output count_bcd, ovf, disp0, disp1);

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment glyph decoder with selectable polarity.
module bcd_to_seg7
    import seq_disp_pkg::*;
#(
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  bcd_t  bcd_i,
    output seg7_t seg_o
);

    seg7_t glyph;

    always_comb begin
        glyph = SEG_ERR;
        for (int unsigned i = 0; i < 10; i++) begin
            if (bcd_i == 4'(i)) begin
                glyph = SEG_DIGIT[i];
            end
        end
        seg_o = ACTIVE_LOW_SEG ? glyph : ~glyph;
    end

endmodule

// File: rtl/detect_count_display.sv
// Two-digit BCD counter of detector strobes with sticky overflow and a
// registered 7-segment display that blinks once overflow has occurred.
module detect_count_display
    import seq_disp_pkg::*;
#(
    parameter bit          SATURATE       = 1'b0,
    parameter int unsigned BLINK_DIV      = 25_000_000,
    parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    detect_count_display_if.slave bus
);

    localparam int unsigned   PW          = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(BLINK_DIV - 1);
    localparam seg7_t         GLYPH_ZERO  = ACTIVE_LOW_SEG ? SEG_DIGIT[0] : ~SEG_DIGIT[0];
    localparam seg7_t         GLYPH_BLANK = ACTIVE_LOW_SEG ? SEG_BLANK : ~SEG_BLANK;

    bcd_t          ones_q, ones_d;
    bcd_t          tens_q, tens_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] presc_q;
    blink_phase_e  phase_q;
    seg7_t         seg_ones, seg_tens;
    seg7_t         disp0_q, disp1_q;

    bcd_to_seg7 #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_dec_ones (.bcd_i(ones_q), .seg_o(seg_ones));
    bcd_to_seg7 #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_dec_tens (.bcd_i(tens_q), .seg_o(seg_tens));

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        ovf_d  = ovf_q;
        if (bus.clr) begin
            ones_d = '0;
            tens_d = '0;
            ovf_d  = 1'b0;
        end else if (bus.ena && bus.det) begin
            if (ones_q == 4'd9 && tens_q == 4'd9) begin
                ovf_d = 1'b1;
                if (!SATURATE) begin
                    ones_d = '0;
                    tens_d = '0;
                end
            end else if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_q  <= '0;
            tens_q  <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            phase_q <= PH_SHOW;
            disp0_q <= GLYPH_ZERO;
            disp1_q <= GLYPH_ZERO;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            ovf_q  <= ovf_d;

            // Prescaler parked at zero until overflow, so the first phase is a full show
            if (bus.clr || !ovf_q) begin
                presc_q <= '0;
                phase_q <= PH_SHOW;
            end else if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                phase_q <= (phase_q == PH_SHOW) ? PH_BLANK : PH_SHOW;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            if (phase_q == PH_BLANK) begin
                disp0_q <= GLYPH_BLANK;
                disp1_q <= GLYPH_BLANK;
            end else begin
                disp0_q <= seg_ones;
                disp1_q <= seg_tens;
            end
        end
    end

    assign bus.count_bcd = {tens_q, ones_q};
    assign bus.ovf       = ovf_q;
    assign bus.disp0     = disp0_q;
    assign bus.disp1     = disp1_q;

endmodule

// File: tb/tb_detect_count_display.sv
// Directed bench for detect_count_display: wrapping, saturating and active-high variants.
module tb_detect_count_display;

    localparam logic [6:0] G0  = 7'b1000000;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] G5  = 7'b0010010;
    localparam logic [6:0] G9  = 7'b0011000;
    localparam logic [6:0] BLK = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    detect_count_display_if if_w ();
    detect_count_display_if if_s ();
    detect_count_display_if if_h ();

    detect_count_display #(.SATURATE(1'b0), .BLINK_DIV(4), .ACTIVE_LOW_SEG(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .bus(if_w.slave));
    detect_count_display #(.SATURATE(1'b1), .BLINK_DIV(4), .ACTIVE_LOW_SEG(1'b1)) u_sat (
        .clk(clk), .rst(rst), .bus(if_s.slave));
    detect_count_display #(.SATURATE(1'b0), .BLINK_DIV(4), .ACTIVE_LOW_SEG(1'b0)) u_hi (
        .clk(clk), .rst(rst), .bus(if_h.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        if_w.ena = 1'b0; if_w.clr = 1'b0; if_w.det = 1'b0;
        if_s.ena = 1'b0; if_s.clr = 1'b0; if_s.det = 1'b0;
        if_h.ena = 1'b0; if_h.clr = 1'b0; if_h.det = 1'b0;
        #1 rst = 1'b0;
        tick(2);
        check("rst_count", if_w.count_bcd, 8'h00);
        check("rst_ovf", 8'(if_w.ovf), 8'h00);
        check("rst_disp0", 8'(if_w.disp0), 8'(G0));
        check("rst_disp1", 8'(if_w.disp1), 8'(G0));
        check("rst_hi_disp0", 8'(if_h.disp0), 8'(7'b0111111));
        check("rst_sat_count", if_s.count_bcd, 8'h00);
        rst = 1'b1;

        // ten isolated pulses, display one cycle behind the count
        if_w.ena = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_w.det = 1'b1;
            tick(1);
            if_w.det = 1'b0;
            if (i == 9) begin
                check("p10_count", if_w.count_bcd, 8'h10);
                check("p10_lag_disp0", 8'(if_w.disp0), 8'(G9));
                check("p10_lag_disp1", 8'(if_w.disp1), 8'(G0));
            end
            tick(1);
        end
        check("p10_disp1", 8'(if_w.disp1), 8'(G1));
        check("p10_disp0", 8'(if_w.disp0), 8'(G0));
        check("p10_ovf", 8'(if_w.ovf), 8'h00);

        if_w.det = 1'b1;
        tick(5);
        if_w.det = 1'b0;
        check("hold5_count", if_w.count_bcd, 8'h15);
        tick(1);
        check("hold5_disp0", 8'(if_w.disp0), 8'(G5));
        check("hold5_disp1", 8'(if_w.disp1), 8'(G1));
        if_w.ena = 1'b0;
        if_w.det = 1'b1;
        tick(5);
        if_w.det = 1'b0;
        check("ena0_count", if_w.count_bcd, 8'h15);

        if_w.ena = 1'b1;
        if_w.det = 1'b1;
        tick(22);
        if_w.det = 1'b0;
        check("c37_count", if_w.count_bcd, 8'h37);
        #2 rst = 1'b0;
        #1;
        check("arst_count", if_w.count_bcd, 8'h00);
        check("arst_ovf", 8'(if_w.ovf), 8'h00);
        check("arst_disp0", 8'(if_w.disp0), 8'(G0));
        check("arst_disp1", 8'(if_w.disp1), 8'(G0));
        @(negedge clk);
        rst = 1'b1;

        // wrap at 99 and blink
        if_w.det = 1'b1;
        tick(99);
        check("c99_count", if_w.count_bcd, 8'h99);
        check("c99_ovf", 8'(if_w.ovf), 8'h00);
        tick(1);
        if_w.det = 1'b0;
        check("wrap_count", if_w.count_bcd, 8'h00);
        check("wrap_ovf", 8'(if_w.ovf), 8'h01);
        check("wrap_lag_disp0", 8'(if_w.disp0), 8'(G9));
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check($sformatf("blink%0d_disp0", k), 8'(if_w.disp0),
                  ((((k - 1) / 4) % 2) == 0) ? 8'(G0) : 8'(BLK));
            check($sformatf("blink%0d_disp1", k), 8'(if_w.disp1),
                  ((((k - 1) / 4) % 2) == 0) ? 8'(G0) : 8'(BLK));
            check($sformatf("blink%0d_count", k), if_w.count_bcd, 8'h00);
        end
        if_w.det = 1'b1;
        tick(1);
        if_w.det = 1'b0;
        check("post_ovf_count", if_w.count_bcd, 8'h01);
        check("post_ovf_sticky", 8'(if_w.ovf), 8'h01);

        // saturating variant, then clr beating det
        if_s.ena = 1'b1;
        if_s.det = 1'b1;
        tick(105);
        if_s.det = 1'b0;
        check("sat_count", if_s.count_bcd, 8'h99);
        check("sat_ovf", 8'(if_s.ovf), 8'h01);
        if_s.clr = 1'b1;
        if_s.det = 1'b1;
        tick(1);
        if_s.clr = 1'b0;
        if_s.det = 1'b0;
        check("clr_count", if_s.count_bcd, 8'h00);
        check("clr_ovf", 8'(if_s.ovf), 8'h00);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check($sformatf("noblink%0d_disp0", k), 8'(if_s.disp0), 8'(G0));
            check($sformatf("noblink%0d_disp1", k), 8'(if_s.disp1), 8'(G0));
        end

        // active-high segments
        if_h.ena = 1'b1;
        if_h.det = 1'b1;
        tick(8);
        if_h.det = 1'b0;
        tick(1);
        check("hi8_disp0", 8'(if_h.disp0), 8'(7'b1111111));
        check("hi8_disp1", 8'(if_h.disp1), 8'(7'b0111111));
        if_h.det = 1'b1;
        tick(92);
        if_h.det = 1'b0;
        check("hi_wrap_count", if_h.count_bcd, 8'h00);
        check("hi_wrap_ovf", 8'(if_h.ovf), 8'h01);
        tick(1);
        check("hi_show_disp0", 8'(if_h.disp0), 8'(7'b0111111));
        tick(4);
        check("hi_blank_disp0", 8'(if_h.disp0), 8'(7'b0000000));
        check("hi_blank_disp1", 8'(if_h.disp1), 8'(7'b0000000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
